bsg_mem_1rw_sync_rmw_ctrl: RTL and testbench
============================================

BSG_MEM_1RW_SYNC_RMW_CTRL -- requirements
Module: bsg_mem_1rw_sync_rmw_ctrl

Interface
REQ-001 SHALL have parameter width_p, no default (-1, must be set), memory word width in bits.
REQ-002 SHALL have parameter mask_width_p, no default (-1), number of write-mask chunks; chunk = width_p/mask_width_p bits.
REQ-003 SHALL have parameter els_p, no default (-1), memory depth; addr_width_lp = `BSG_SAFE_CLOG2(els_p).
REQ-004 SHALL have ports, in order:
 clk_i  in  1  the single clock
 reset_i  in  1  synchronous, active-high reset
 v_i  in  1  request valid
 w_i  in  1  1=write, 0=read
 addr_i  in  addr_width_lp  request address
 data_i  in  width_p  write data
 w_mask_i  in  mask_width_p  bit i enables chunk i
 ready_o  out  1  request accepted when v_i & ready_o
 v_o  out  1  read data valid
 data_o  out  width_p  read data
 yumi_i  in  1  consumer takes read data; legal only when v_o
 mem_v_o / mem_w_o  out  1 each  memory port enable / write
 mem_addr_o  out  addr_width_lp  memory address
 mem_data_o  out  width_p  memory write data
 mem_data_i  in  width_p  memory read data, valid the cycle after a read enable

Function
REQ-005 SHALL drive an unmasked 1rw synchronous memory so that masked writes are performed as read-modify-write.
REQ-006 FSM states SHALL be IDLE, RD_WAIT, RMW_WRITE.
REQ-007 ready_o SHALL be 1 only in IDLE with v_o == 0.
REQ-008 Read accept (cycle 0): mem_v_o=1, mem_w_o=0, mem_addr_o=addr_i combinationally; go to RD_WAIT.
REQ-009 RD_WAIT (cycle 1): capture mem_data_i into output register; v_o=1 from cycle 2; go to IDLE; no memory access in cycle 1.
REQ-010 v_o/data_o SHALL hold stable until the cycle yumi_i=1; v_o clears the following cycle.
REQ-011 Partial-mask write accept (cycle 0): issue memory read at addr_i; register addr, data, mask; go to RMW_WRITE.
REQ-012 RMW_WRITE (cycle 1): mem_v_o=1, mem_w_o=1, same address, mem_data_o chunk i = masked ? registered data chunk i : mem_data_i chunk i; return to IDLE.
REQ-013 Write with w_mask_i all zero SHALL be accepted with no memory access and remain IDLE.
REQ-014 Write with w_mask_i all ones SHALL follow REQ-011/012 unless REQ-020 applies.
REQ-015 mem_v_o SHALL be 0 in every cycle not listed in REQ-008/011/012/020.
REQ-016 Requests SHALL be served strictly in order; a write does not disturb a pending read-data buffer.

Reset
REQ-017 While reset_i=1 and the cycle after: state=IDLE, v_o=0, mem_v_o=0, mem_w_o=0, ready_o=0.
REQ-018 Reset during RD_WAIT or RMW_WRITE SHALL abandon the operation; no memory write occurs in or after the reset cycle.
REQ-019 data_o SHALL reset to 0.

Configuration
REQ-020 With BSG_MEM_RMW_FULL_MASK_BYPASS_EN defined, an all-ones write SHALL be a direct single-cycle write in cycle 0 (mem_v_o=1, mem_w_o=1, mem_data_o=data_i), staying IDLE; undefined, it SHALL use the two-cycle RMW path.

Structure
REQ-021 State enum and chunk-width helper constant SHALL reside in package bsg_mem_rmw_pkg.
REQ-022 Chunk merge SHALL be sub-module bsg_mem_rmw_merge (combinational, width_p/mask_width_p parameters).
REQ-023 SHALL assert (width_p % mask_width_p)==0 and error otherwise.

Verification (width_p=32, mask_width_p=4, els_p=16)
REQ-024 Write addr 3 data 0xAABBCCDD mask 0xF, read addr 3 -> data_o=0xAABBCCDD, v_o 2 cycles after read accept.
REQ-025 Mem[5]=0x11223344, write 0xFFEEDDCC mask 0x5 -> cycle 1 mem_data_o=0x11EE33CC; ready_o low in cycle 1.
REQ-026 Read with yumi_i held 0 for 4 cycles -> v_o/data_o stable, ready_o=0 throughout; yumi -> ready_o=1 next cycle.
REQ-027 Write mask 0x0 -> no mem_v_o pulse; ready_o stays 1.
REQ-028 reset_i asserted in RMW_WRITE cycle -> no mem_w_o; memory unchanged; IDLE after.
REQ-029 Full-mask write with and without BSG_MEM_RMW_FULL_MASK_BYPASS_EN -> 1 vs 2 cycles, identical memory contents.

Source files
------------

// File: rtl/bsg_mem_rmw_pkg.sv
// Shared state encoding and chunk-width helper for the 1rw read-modify-write controller.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package bsg_mem_rmw_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RD_WAIT   = 2'd1,
        RMW_WRITE = 2'd2
    } rmw_state_e;

    function automatic int chunk_width(input int width, input int mask_width);
        return width / mask_width;
    endfunction

endpackage

// File: rtl/bsg_mem_rmw_merge.sv
// Per-chunk select between freshly read memory data and registered write data.
module bsg_mem_rmw_merge
    import bsg_mem_rmw_pkg::*;
#(
    parameter int width_p      = -1,
    parameter int mask_width_p = -1
) (
    input  logic [width_p-1:0]      mem_data,
    input  logic [width_p-1:0]      wr_data,
    input  logic [mask_width_p-1:0] mask,
    output logic [width_p-1:0]      merged
);

    localparam int chunk_lp = chunk_width(width_p, mask_width_p);

    for (genvar i = 0; i < mask_width_p; i++) begin : g_chunk
        assign merged[i*chunk_lp +: chunk_lp] = mask[i] ? wr_data[i*chunk_lp +: chunk_lp]
                                                         : mem_data[i*chunk_lp +: chunk_lp];
    end

endmodule

// File: rtl/bsg_mem_1rw_sync_rmw_ctrl.sv
// Masked-write front end for an unmasked 1rw synchronous memory; partial writes become read-modify-write.
// Define BSG_MEM_RMW_FULL_MASK_BYPASS_EN to write all-ones-mask requests directly in one cycle.
module bsg_mem_1rw_sync_rmw_ctrl
    import bsg_mem_rmw_pkg::*;
#(
    parameter int width_p            = -1,
    parameter int mask_width_p       = -1,
    parameter int els_p              = -1,
    localparam int addr_width_lp     = `BSG_SAFE_CLOG2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [mask_width_p-1:0]  w_mask_i,
    output logic                     ready_o,
    output logic                     v_o,
    output logic [width_p-1:0]       data_o,
    input  logic                     yumi_i,
    output logic                     mem_v_o,
    output logic                     mem_w_o,
    output logic [addr_width_lp-1:0] mem_addr_o,
    output logic [width_p-1:0]       mem_data_o,
    input  logic [width_p-1:0]       mem_data_i
);

    if ((width_p % mask_width_p) != 0) begin : g_bad_mask
        $error("bsg_mem_1rw_sync_rmw_ctrl: width_p must be a multiple of mask_width_p");
    end

    rmw_state_e state_q, state_n;

    logic                     v_q, reset_q;
    logic [width_p-1:0]       data_q, wdata_q, merged;
    logic [addr_width_lp-1:0] addr_q;
    logic [mask_width_p-1:0]  mask_q;
    logic                     mask_none, direct_write;
    logic                     rd_accept, rmw_start;

    assign mask_none = ~|w_mask_i;

`ifdef BSG_MEM_RMW_FULL_MASK_BYPASS_EN
    assign direct_write = &w_mask_i;
`else
    assign direct_write = 1'b0;
`endif

    assign rd_accept = v_i & ready_o & ~w_i;
    assign rmw_start = v_i & ready_o & w_i & ~mask_none & ~direct_write;

    assign v_o    = v_q;
    assign data_o = data_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE: begin
                if (rd_accept)      state_n = RD_WAIT;
                else if (rmw_start) state_n = RMW_WRITE;
            end
            RD_WAIT:   state_n = IDLE;
            RMW_WRITE: state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // Memory strobes are masked by reset so an interrupted RMW never writes.
    always_comb begin
        ready_o    = 1'b0;
        mem_v_o    = 1'b0;
        mem_w_o    = 1'b0;
        mem_addr_o = addr_i;
        mem_data_o = data_i;
        case (state_q)
            IDLE: begin
                ready_o = ~v_q & ~reset_i & ~reset_q;
                if (v_i & ready_o & (~w_i | ~mask_none)) begin
                    mem_v_o = 1'b1;
                    mem_w_o = w_i & direct_write;
                end
            end
            RMW_WRITE: begin
                mem_v_o    = ~reset_i;
                mem_w_o    = ~reset_i;
                mem_addr_o = addr_q;
                mem_data_o = merged;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        reset_q <= reset_i;
        if (reset_i) begin
            v_q    <= 1'b0;
            data_q <= '0;
        end else if (state_q == RD_WAIT) begin
            v_q    <= 1'b1;
            data_q <= mem_data_i;
        end else if (yumi_i) begin
            v_q    <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rmw_start) begin
            addr_q  <= addr_i;
            wdata_q <= data_i;
            mask_q  <= w_mask_i;
        end
    end

    bsg_mem_rmw_merge #(
        .width_p      (width_p),
        .mask_width_p (mask_width_p)
    ) merge (
        .mem_data (mem_data_i),
        .wr_data  (wdata_q),
        .mask     (mask_q),
        .merged   (merged)
    );

endmodule

// File: tb/tb_bsg_mem_1rw_sync_rmw_ctrl.sv
// Directed bench for the RMW controller against a behavioural 1rw synchronous memory.
module tb_bsg_mem_1rw_sync_rmw_ctrl;

    localparam int W = 32;
    localparam int M = 4;
    localparam int E = 16;
    localparam int A = 4;

`ifdef BSG_MEM_RMW_FULL_MASK_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_i = 1'b1;
    logic         v_i = 1'b0, w_i = 1'b0, yumi_i = 1'b0;
    logic [A-1:0] addr_i = '0;
    logic [W-1:0] data_i = '0;
    logic [M-1:0] w_mask_i = '0;
    logic         ready_o, v_o, mem_v_o, mem_w_o;
    logic [W-1:0] data_o, mem_data_o, mem_data_i;
    logic [A-1:0] mem_addr_o;

    logic [W-1:0] mem [E];
    logic [W-1:0] mem_rd;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bsg_mem_1rw_sync_rmw_ctrl #(.width_p(W), .mask_width_p(M), .els_p(E)) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .w_i(w_i), .addr_i(addr_i),
        .data_i(data_i), .w_mask_i(w_mask_i), .ready_o(ready_o), .v_o(v_o),
        .data_o(data_o), .yumi_i(yumi_i), .mem_v_o(mem_v_o), .mem_w_o(mem_w_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
    );

    always @(posedge clk) begin
        if (mem_v_o) begin
            if (mem_w_o) mem[mem_addr_o] <= mem_data_o;
            else         mem_rd <= mem[mem_addr_o];
        end
    end
    assign mem_data_i = mem_rd;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        step();
        step();
        @(negedge clk);
        n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL rst_ready got %0b exp 0", ready_o); end
        n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("FAIL rst_v_o got %0b exp 0", v_o); end
        n_cmp++; if (mem_v_o !== 1'b0) begin n_err++; $display("FAIL rst_mem_v got %0b exp 0", mem_v_o); end
        n_cmp++; if (mem_w_o !== 1'b0) begin n_err++; $display("FAIL rst_mem_w got %0b exp 0", mem_w_o); end
        n_cmp++; if (data_o !== 32'h0) begin n_err++; $display("FAIL rst_data got %h exp 0", data_o); end
        step();
        reset_i = 1'b0;
        v_i = 1'b1; w_i = 1'b0; addr_i = 4'd0;
        @(negedge clk);
        n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL post_rst_ready got %0b exp 0", ready_o); end
        n_cmp++; if (mem_v_o !== 1'b0) begin n_err++; $display("FAIL post_rst_mem_v got %0b exp 0", mem_v_o); end
        step();
        v_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL idle_ready got %0b exp 1", ready_o); end
        step();
    endtask

    task automatic test_full_write_read();
        v_i = 1'b1; w_i = 1'b1; addr_i = 4'd3; data_i = 32'hAABBCCDD; w_mask_i = 4'hF;
        @(negedge clk);
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL fw_ready got %0b exp 1", ready_o); end
        n_cmp++; if (mem_v_o !== 1'b1) begin n_err++; $display("FAIL fw_mem_v got %0b exp 1", mem_v_o); end
        n_cmp++; if (mem_w_o !== BYP) begin n_err++; $display("FAIL fw_mem_w got %0b exp %0b", mem_w_o, BYP); end
        n_cmp++; if (mem_addr_o !== 4'd3) begin n_err++; $display("FAIL fw_addr got %0d exp 3", mem_addr_o); end
        step();
        v_i = 1'b0;
`ifndef BSG_MEM_RMW_FULL_MASK_BYPASS_EN
        @(negedge clk);
        n_cmp++; if (mem_w_o !== 1'b1) begin n_err++; $display("FAIL fw_rmw_w got %0b exp 1", mem_w_o); end
        n_cmp++; if (mem_data_o !== 32'hAABBCCDD) begin n_err++; $display("FAIL fw_rmw_data got %h exp aabbccdd", mem_data_o); end
        n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL fw_rmw_ready got %0b exp 0", ready_o); end
        step();
`endif
        v_i = 1'b1; w_i = 1'b0; addr_i = 4'd3;
        @(negedge clk);
        n_cmp++; if (mem_v_o !== 1'b1 || mem_w_o !== 1'b0) begin n_err++; $display("FAIL rd_issue got v=%0b w=%0b exp v=1 w=0", mem_v_o, mem_w_o); end
        step();
        v_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_v_o !== 1'b0) begin n_err++; $display("FAIL rd_wait_mem_v got %0b exp 0", mem_v_o); end
        n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("FAIL rd_wait_v_o got %0b exp 0", v_o); end
        step();
        @(negedge clk);
        n_cmp++; if (v_o !== 1'b1) begin n_err++; $display("FAIL rd_v_o got %0b exp 1", v_o); end
        n_cmp++; if (data_o !== 32'hAABBCCDD) begin n_err++; $display("FAIL rd_data got %h exp aabbccdd", data_o); end
        yumi_i = 1'b1;
        step();
        yumi_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("FAIL rd_yumi_v_o got %0b exp 0", v_o); end
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL rd_yumi_ready got %0b exp 1", ready_o); end
        step();
    endtask

    task automatic test_partial_mask();
        v_i = 1'b1; w_i = 1'b1; addr_i = 4'd5; data_i = 32'h11223344; w_mask_i = 4'hF;
        step();
        v_i = 1'b0;
        step();
        v_i = 1'b1; w_i = 1'b1; addr_i = 4'd5; data_i = 32'hFFEEDDCC; w_mask_i = 4'h5;
        @(negedge clk);
        n_cmp++; if (mem[5] !== 32'h11223344) begin n_err++; $display("FAIL pm_preload got %h exp 11223344", mem[5]); end
        n_cmp++; if (mem_v_o !== 1'b1 || mem_w_o !== 1'b0) begin n_err++; $display("FAIL pm_rd got v=%0b w=%0b exp v=1 w=0", mem_v_o, mem_w_o); end
        step();
        v_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_v_o !== 1'b1 || mem_w_o !== 1'b1) begin n_err++; $display("FAIL pm_wr got v=%0b w=%0b exp v=1 w=1", mem_v_o, mem_w_o); end
        n_cmp++; if (mem_addr_o !== 4'd5) begin n_err++; $display("FAIL pm_addr got %0d exp 5", mem_addr_o); end
        n_cmp++; if (mem_data_o !== 32'h11EE33CC) begin n_err++; $display("FAIL pm_data got %h exp 11ee33cc", mem_data_o); end
        n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL pm_ready got %0b exp 0", ready_o); end
        step();
        @(negedge clk);
        n_cmp++; if (mem[5] !== 32'h11EE33CC) begin n_err++; $display("FAIL pm_mem got %h exp 11ee33cc", mem[5]); end
        n_cmp++; if (mem_v_o !== 1'b0 || ready_o !== 1'b1) begin n_err++; $display("FAIL pm_done got v=%0b rdy=%0b exp v=0 rdy=1", mem_v_o, ready_o); end
        step();
    endtask

    task automatic test_yumi_hold();
        v_i = 1'b1; w_i = 1'b0; addr_i = 4'd5;
        step();
        v_i = 1'b0;
        step();
        v_i = 1'b1; w_i = 1'b0; addr_i = 4'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (v_o !== 1'b1 || data_o !== 32'h11EE33CC) begin n_err++; $display("FAIL hold_out[%0d] got v=%0b d=%h exp v=1 d=11ee33cc", i, v_o, data_o); end
            n_cmp++; if (ready_o !== 1'b0 || mem_v_o !== 1'b0) begin n_err++; $display("FAIL hold_stall[%0d] got rdy=%0b mv=%0b exp 0 0", i, ready_o, mem_v_o); end
            step();
        end
        v_i = 1'b0;
        yumi_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (v_o !== 1'b1 || ready_o !== 1'b0) begin n_err++; $display("FAIL hold_yumi got v=%0b rdy=%0b exp v=1 rdy=0", v_o, ready_o); end
        step();
        yumi_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (v_o !== 1'b0 || ready_o !== 1'b1) begin n_err++; $display("FAIL hold_after got v=%0b rdy=%0b exp v=0 rdy=1", v_o, ready_o); end
        step();
    endtask

    task automatic test_zero_mask();
        v_i = 1'b1; w_i = 1'b1; addr_i = 4'd3; data_i = 32'hDEADBEEF; w_mask_i = 4'h0;
        @(negedge clk);
        n_cmp++; if (ready_o !== 1'b1 || mem_v_o !== 1'b0) begin n_err++; $display("FAIL zm_accept got rdy=%0b mv=%0b exp 1 0", ready_o, mem_v_o); end
        step();
        v_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (ready_o !== 1'b1 || mem_v_o !== 1'b0) begin n_err++; $display("FAIL zm_next got rdy=%0b mv=%0b exp 1 0", ready_o, mem_v_o); end
        n_cmp++; if (mem[3] !== 32'hAABBCCDD) begin n_err++; $display("FAIL zm_mem got %h exp aabbccdd", mem[3]); end
        step();
    endtask

    task automatic test_reset_in_rmw();
        v_i = 1'b1; w_i = 1'b1; addr_i = 4'd3; data_i = 32'h12345678; w_mask_i = 4'h3;
        @(negedge clk);
        n_cmp++; if (mem_v_o !== 1'b1 || mem_w_o !== 1'b0) begin n_err++; $display("FAIL rr_rd got v=%0b w=%0b exp v=1 w=0", mem_v_o, mem_w_o); end
        step();
        v_i = 1'b0;
        reset_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem_v_o !== 1'b0 || mem_w_o !== 1'b0) begin n_err++; $display("FAIL rr_kill got v=%0b w=%0b exp 0 0", mem_v_o, mem_w_o); end
        n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL rr_ready got %0b exp 0", ready_o); end
        step();
        reset_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_v_o !== 1'b0 || ready_o !== 1'b0) begin n_err++; $display("FAIL rr_post got mv=%0b rdy=%0b exp 0 0", mem_v_o, ready_o); end
        step();
        @(negedge clk);
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL rr_idle got %0b exp 1", ready_o); end
        n_cmp++; if (mem[3] !== 32'hAABBCCDD) begin n_err++; $display("FAIL rr_mem got %h exp aabbccdd", mem[3]); end
        v_i = 1'b1; w_i = 1'b0; addr_i = 4'd3;
        step();
        v_i = 1'b0;
        step();
        @(negedge clk);
        n_cmp++; if (v_o !== 1'b1 || data_o !== 32'hAABBCCDD) begin n_err++; $display("FAIL rr_read got v=%0b d=%h exp v=1 d=aabbccdd", v_o, data_o); end
        yumi_i = 1'b1;
        step();
        yumi_i = 1'b0;
    endtask

    task automatic test_full_mask_cycles();
        v_i = 1'b1; w_i = 1'b1; addr_i = 4'd7; data_i = 32'hCAFEF00D; w_mask_i = 4'hF;
        @(negedge clk);
        n_cmp++; if (mem_v_o !== 1'b1 || mem_w_o !== BYP) begin n_err++; $display("FAIL fm_c0 got v=%0b w=%0b exp v=1 w=%0b", mem_v_o, mem_w_o, BYP); end
        step();
        v_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (ready_o !== BYP) begin n_err++; $display("FAIL fm_c1_ready got %0b exp %0b", ready_o, BYP); end
        step();
        @(negedge clk);
        n_cmp++; if (mem[7] !== 32'hCAFEF00D) begin n_err++; $display("FAIL fm_mem got %h exp cafef00d", mem[7]); end
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL fm_ready got %0b exp 1", ready_o); end
        step();
    endtask

    initial begin
        test_reset();
        test_full_write_read();
        test_partial_mask();
        test_yumi_hold();
        test_zero_mask();
        test_reset_in_rmw();
        test_full_mask_cycles();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
